sobel_frame_ctrl: RTL

//  Frame sequencer for the rgb->grayscale->sobel pipeline. On start, streams IMG_WIDTH*IMG_HEIGHT
//  RGB pixels from input memory into the rgb fifo. In parallel, drains the sobel fifo into output

---
 rtl/sobel_frame_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the rgb -> grayscale -> sobel pipeline.
// Feeds IMG_WIDTH*IMG_HEIGHT RGB pixels from input memory into the rgb fifo and, in parallel,
// drains the sobel fifo into output memory, pulsing o_done after the last output write.
// Optional: define SOBEL_FRAME_CYCLES_EN to add the o_frame_cycles RUN-cycle counter.
module sobel_frame_ctrl #(
   parameter int unsigned IMG_WIDTH    = 720,
   parameter int unsigned IMG_HEIGHT   = 540,
   parameter int unsigned RGB_DWIDTH   = 24,
   parameter int unsigned SOBEL_DWIDTH = 8,
   parameter int unsigned ADDR_WIDTH   = 19
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_start,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_in_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   o_in_mem_rd_addr,
   input  logic [RGB_DWIDTH-1:0]   i_in_mem_rd_data,
   output logic                    o_fifo_rgb_wr_en,
   output logic [RGB_DWIDTH-1:0]   o_fifo_rgb_din,
   input  logic                    i_fifo_rgb_full,
   output logic                    o_fifo_sobel_rd_en,
   input  logic [SOBEL_DWIDTH-1:0] i_fifo_sobel_dout,
   input  logic                    i_fifo_sobel_empty,
`ifdef SOBEL_FRAME_CYCLES_EN
   output logic [31:0]             o_frame_cycles,
`endif
   output logic                    o_out_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]   o_out_mem_wr_addr,
   output logic [SOBEL_DWIDTH-1:0] o_out_mem_wr_data
);

   // One extra bit so the counters can hold N without wrapping.
   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] NPIX = CW'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [CW-1:0] LAST = NPIX - CW'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CW-1:0]           r_rd_cnt;
   logic [CW-1:0]           r_wr_cnt;
   logic                    r_pending;
   logic                    r_hold_valid;
   logic [RGB_DWIDTH-1:0]   r_hold;

   logic w_run;
   logic w_start_acc;
   logic w_rgb_wr_en;
   logic w_occ0;
   logic w_occ1;
   logic w_issue;
   logic w_drain;

   // Feed/drain handshake decode.
   always_comb begin
      w_run       = (r_state == StRun);
      w_start_acc = (r_state == StIdle) & i_start;
      w_rgb_wr_en = w_run & (r_hold_valid | r_pending) & ~i_fifo_rgb_full;
      w_occ0      = ~r_pending & ~r_hold_valid;
      w_occ1      = r_pending ^ r_hold_valid;
      // Only issue when the result is guaranteed a slot: empty, or the single item leaves now.
      w_issue     = w_run & (r_rd_cnt < NPIX) & (w_occ0 | (w_occ1 & w_rgb_wr_en));
      w_drain     = w_run & ~i_fifo_sobel_empty & (r_wr_cnt < NPIX);
   end

   // Next-state decode for the frame FSM.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_nxt = StRun;
         StRun:   if (w_drain && (r_wr_cnt == LAST)) w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Frame FSM state register.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_state <= StIdle;
      else          r_state <= w_state_nxt;
   end

   // Read and write pixel counters, cleared on an accepted start.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else if (w_start_acc) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_issue) r_rd_cnt <= r_rd_cnt + CW'(1);
         if (w_drain) r_wr_cnt <= r_wr_cnt + CW'(1);
      end
   end

   // Read-pending flag and one-entry skid register absorbing data returned under backpressure.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_pending    <= 1'b0;
         r_hold_valid <= 1'b0;
         r_hold       <= '0;
      end else if (!w_run) begin
         r_pending    <= 1'b0;
         r_hold_valid <= 1'b0;
      end else begin
         r_pending <= w_issue;
         if (r_pending && (r_hold_valid || i_fifo_rgb_full)) begin
            r_hold       <= i_in_mem_rd_data;
            r_hold_valid <= 1'b1;
         end else if (r_hold_valid && w_rgb_wr_en) begin
            r_hold_valid <= 1'b0;
         end
      end
   end

`ifdef SOBEL_FRAME_CYCLES_EN
   logic [31:0] r_frame_cycles;

   // Saturating count of RUN cycles; holds after the frame ends.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)                           r_frame_cycles <= '0;
      else if (w_start_acc)                   r_frame_cycles <= '0;
      else if (w_run && (r_frame_cycles != '1)) r_frame_cycles <= r_frame_cycles + 32'd1;
   end

   assign o_frame_cycles = r_frame_cycles;
`endif

   // Outputs are forced to zero whenever their strobe is low.
   always_comb begin
      o_busy             = w_run;
      o_done             = (r_state == StDone);
      o_in_mem_rd_en     = w_issue;
      o_in_mem_rd_addr   = w_issue ? r_rd_cnt[ADDR_WIDTH-1:0] : '0;
      o_fifo_rgb_wr_en   = w_rgb_wr_en;
      o_fifo_rgb_din     = '0;
      if (w_rgb_wr_en) o_fifo_rgb_din = r_hold_valid ? r_hold : i_in_mem_rd_data;
      o_fifo_sobel_rd_en = w_drain;
      o_out_mem_wr_en    = w_drain;
      o_out_mem_wr_addr  = w_drain ? r_wr_cnt[ADDR_WIDTH-1:0] : '0;
      o_out_mem_wr_data  = w_drain ? i_fifo_sobel_dout : '0;
   end

endmodule
